// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and the mem_responder (slave).
interface mem_responder_if;
   logic        req;
   logic        we;
   logic [5:0]  addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        busy;

   modport master (output req, we, addr, wdata, input ack, rdata, busy);
   modport slave  (input req, we, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/mem_responder.sv
// 64 x 32 single-port memory responder with a req/ack handshake and registered outputs.
// Optional wait states are enabled by defining MEM_WAIT_STATE_EN (length set by WAIT_CYCLES).
module mem_responder #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_responder_if.slave   bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
`ifdef MEM_WAIT_STATE_EN
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
`endif
   localparam logic [1:0] S_ACK  = 2'd2;

   if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_wait_range
      $error("mem_responder: WAIT_CYCLES must be within 1..15");
   end

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic        enter_ack_s;
   logic        start_s;
   logic        we_r;
   logic [5:0]  addr_r;
   logic [31:0] wdata_r;
   logic        ack_r;
   logic        busy_r;
   logic [31:0] rdata_r;
   logic        acc_we_s;
   logic [5:0]  acc_addr_s;
   logic [31:0] acc_wdata_s;
   logic [31:0] mem_r [0:63];
`ifdef MEM_WAIT_STATE_EN
   logic [3:0]  cnt_r;
`endif

   assign start_s   = (state_r == S_IDLE) && bus.req;
   assign bus.ack   = ack_r;
   assign bus.busy  = busy_r;
   assign bus.rdata = rdata_r;

   // Next-state decode; enter_ack_s marks the edge that performs the access.
   always_comb begin
      state_nxt_s = state_r;
      enter_ack_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (bus.req) begin
`ifdef MEM_WAIT_STATE_EN
               state_nxt_s = S_WAIT;
`else
               state_nxt_s = S_ACK;
               enter_ack_s = 1'b1;
`endif
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
`ifdef MEM_WAIT_STATE_EN
         S_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_nxt_s = S_ACK;
               enter_ack_s = 1'b1;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
`endif
         S_ACK:   state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Access operands: straight from the bus when ACK is entered from IDLE, else the latched copy.
   always_comb begin
      if (state_r == S_IDLE) begin
         acc_we_s    = bus.we;
         acc_addr_s  = bus.addr;
         acc_wdata_s = bus.wdata;
      end else begin
         acc_we_s    = we_r;
         acc_addr_s  = addr_r;
         acc_wdata_s = wdata_r;
      end
   end

   // Storage write port; contents deliberately survive reset, but a reset edge blocks the write.
   always_ff @(posedge clk) begin
      if (rst_n && enter_ack_s && acc_we_s) begin
         mem_r[acc_addr_s] <= acc_wdata_s;
      end
   end

   // Control state, request capture and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         we_r    <= 1'b0;
         addr_r  <= 6'd0;
         wdata_r <= 32'd0;
         ack_r   <= 1'b0;
         busy_r  <= 1'b0;
         rdata_r <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         ack_r   <= enter_ack_s;
         busy_r  <= (state_nxt_s != S_IDLE);
         if (start_s) begin
            we_r    <= bus.we;
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
         end
         if (enter_ack_s && !acc_we_s) begin
            rdata_r <= mem_r[acc_addr_s];
         end
      end
   end

`ifdef MEM_WAIT_STATE_EN
   // Wait-state counter: loaded on request capture, counts down while waiting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= 4'd0;
      end else if (start_s) begin
         cnt_r <= WAIT_LOAD;
      end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
         cnt_r <= cnt_r - 4'd1;
      end
   end
`endif

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL provide parameter: WAIT_CYCLES, 2, number of wait-state cycles inserted per transaction when MEM_WAIT_STATE_EN is defined; legal range 1..15.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port: req  input  1  initiator request strobe; sampled only in IDLE.
REQ-005 SHALL provide port: we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 SHALL provide port: addr  input  6  word address into 64 x 32 storage; sampled with req.
REQ-007 SHALL provide port: wdata  input  32  write data; sampled with req.
REQ-008 SHALL provide port: ack  output  1  transaction-complete pulse, registered.
REQ-009 SHALL provide port: rdata  output  32  read data, registered, valid while ack=1 for reads.
REQ-010 SHALL provide port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-012 IDLE with req=1 at an edge SHALL latch we, addr, wdata into internal registers and go to ACK (macro undefined) or WAIT (macro defined), loading wait counter with WAIT_CYCLES-1.
REQ-013 IDLE with req=0 SHALL remain in IDLE; ack=0.
REQ-014 WAIT SHALL decrement counter each edge; at counter=0 the next edge SHALL go to ACK.
REQ-015 The edge entering ACK SHALL perform the access: write stores latched wdata at latched addr; read loads mem[latched addr] into rdata.
REQ-016 rdata SHALL hold its previous value on write transactions and in all other states.
REQ-017 ack SHALL be 1 for exactly one cycle (state ACK); ACK SHALL unconditionally return to IDLE on the next edge.
REQ-018 Latency: ack high in cycle 1 after the sampling edge (macro undefined) or cycle 1+WAIT_CYCLES (macro defined); max throughput one transaction per 2 cycles without waits.
REQ-019 Changes on req, we, addr, wdata while busy=1 SHALL be ignored; req held high through ACK SHALL start a new transaction only from the following IDLE cycle.
REQ-020 Address 63 SHALL be accessed normally; no wrap or error handling (6-bit address covers full storage).
REQ-021 Write then read of same address in consecutive transactions SHALL return the written data.

Reset
REQ-022 rst_n=0 at an edge SHALL force state IDLE, ack=0, busy=0, rdata=32'h0, counter=0, latched registers=0.
REQ-023 Reset SHALL take priority over all transitions; reset at the edge that would enter ACK SHALL suppress the write and ack.
REQ-024 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-025 Macro MEM_WAIT_STATE_EN defined SHALL include WAIT state and counter, latency per REQ-018 with WAIT_CYCLES.
REQ-026 Macro MEM_WAIT_STATE_EN undefined SHALL omit WAIT state and counter logic; IDLE goes directly to ACK; WAIT_CYCLES ignored.

Verification
REQ-027 Macro undefined: write addr=5 wdata=32'hDEADBEEF, then read addr=5 -> ack one cycle after each sampling edge, rdata=32'hDEADBEEF in read ack cycle.
REQ-028 Macro defined, WAIT_CYCLES=3: read addr=63 after write 32'h0000_00FF -> busy high 4 cycles, ack in cycle 4 after sampling edge, rdata=32'h0000_00FF.
REQ-029 req held high continuously for 6 cycles, macro undefined -> exactly 3 ack pulses, alternating cycles.
REQ-030 Change addr 5->9 and wdata during WAIT -> write lands at addr 5 with original data; addr 9 unchanged.
REQ-031 rst_n=0 in the cycle before ACK during write of 32'h1234_5678 to addr 7 (prior 32'h0) -> no ack, busy=0, rdata=0; subsequent read of addr 7 returns 32'h0.
REQ-032 Reset while IDLE after writes -> previously written words still readable with original values.
